// File: rtl/fir_sample_scheduler.sv
// Sample scheduler in front of the FIR datapath: queues input samples, issues one write
// strobe per sample slot, captures the filter result and tracks underrun/overrun/timeout.
module fir_sample_scheduler #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned OUT_W      = 32,
    parameter int unsigned PERIOD_W   = 16,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_enable,
    input  logic [PERIOD_W-1:0] i_period,
    input  logic [DATA_W-1:0]   i_sample,
    input  logic                i_sample_valid,
    output logic                o_sample_ready,
    output logic [DATA_W-1:0]   o_fir_data,
    output logic                o_fir_wr,
    input  logic [OUT_W-1:0]    i_fir_out,
    input  logic                i_fir_rdy,
    output logic [OUT_W-1:0]    o_result,
    output logic                o_result_valid,
    output logic [7:0]          o_underrun_cnt,
    output logic [7:0]          o_overrun_cnt,
    output logic                o_timeout,
    output logic                o_busy
);
    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_WAIT_RDY} state_t;

    state_t                state_q, state_d;
    logic [PERIOD_W-1:0]   cnt_q, cnt_d, per_q, per_d, per_in;
    logic [DATA_W-1:0]     mem_q [FIFO_DEPTH];
    logic [DATA_W-1:0]     mem_d [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         fcnt_q, fcnt_d;
    logic                  ready_q, ready_d;
    logic [DATA_W-1:0]     fir_data_q, fir_data_d;
    logic                  fir_wr_q, fir_wr_d;
    logic                  rdy_prev_q;
    logic [OUT_W-1:0]      result_q, result_d;
    logic                  result_valid_q, result_valid_d;
    logic [7:0]            underrun_q, underrun_d, overrun_q, overrun_d;
    logic                  timeout_q, timeout_d;
    logic                  busy_q, busy_d;
    logic [TW-1:0]         wait_q, wait_d;
    logic                  tick, push, pop, rdy_edge;

    always_comb begin
        per_in   = (i_period < PERIOD_W'(2)) ? PERIOD_W'(2) : i_period;
        tick     = i_enable && (state_q != S_IDLE) && (cnt_q == per_q - PERIOD_W'(1));
        push     = i_sample_valid && ready_q;
        rdy_edge = i_fir_rdy && !rdy_prev_q;
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        per_d          = per_q;
        mem_d          = mem_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        fcnt_d         = fcnt_q;
        fir_data_d     = fir_data_q;
        fir_wr_d       = 1'b0;
        result_d       = result_q;
        result_valid_d = 1'b0;
        underrun_d     = underrun_q;
        overrun_d      = overrun_q;
        timeout_d      = timeout_q;
        wait_d         = wait_q;
        pop            = 1'b0;

        // Slot counter; a new period is only picked up at a wrap or while idle
        if (state_q == S_IDLE) begin
            cnt_d = '0;
            per_d = per_in;
        end else if (i_enable) begin
            if (tick) begin
                cnt_d = '0;
                per_d = per_in;
            end else begin
                cnt_d = cnt_q + PERIOD_W'(1);
            end
        end

        case (state_q)
            S_IDLE: begin
                if (i_enable) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (!i_enable) begin
                    state_d = S_IDLE;
                end else if (tick) begin
                    if (fcnt_q != '0) begin
                        pop        = 1'b1;
                        fir_data_d = mem_q[rd_ptr_q];
                        fir_wr_d   = 1'b1;
                        wait_d     = '0;
                        state_d    = S_WAIT_RDY;
                    end else if (underrun_q != 8'hFF) begin
                        underrun_d = underrun_q + 8'd1;
                    end
                end
            end
            S_WAIT_RDY: begin
                wait_d = wait_q + TW'(1);
                if (tick && overrun_q != 8'hFF) overrun_d = overrun_q + 8'd1;
                // The ready edge is ignored in the strobe cycle itself
                if (!fir_wr_q && rdy_edge) begin
                    result_d       = i_fir_out;
                    result_valid_d = 1'b1;
                    state_d        = i_enable ? S_WAIT : S_IDLE;
                end else if (wait_q == TW'(TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = S_WAIT;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (push) begin
            mem_d[wr_ptr_q] = i_sample;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, pop})
            2'b10:   fcnt_d = fcnt_q + CW'(1);
            2'b01:   fcnt_d = fcnt_q - CW'(1);
            default: fcnt_d = fcnt_q;
        endcase
        ready_d = (fcnt_d != CW'(FIFO_DEPTH));
        busy_d  = (state_d == S_WAIT_RDY);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            per_q          <= PERIOD_W'(2);
            mem_q          <= '{default: '0};
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            fcnt_q         <= '0;
            ready_q        <= 1'b1;
            fir_data_q     <= '0;
            fir_wr_q       <= 1'b0;
            rdy_prev_q     <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            underrun_q     <= '0;
            overrun_q      <= '0;
            timeout_q      <= 1'b0;
            busy_q         <= 1'b0;
            wait_q         <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            per_q          <= per_d;
            mem_q          <= mem_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            fcnt_q         <= fcnt_d;
            ready_q        <= ready_d;
            fir_data_q     <= fir_data_d;
            fir_wr_q       <= fir_wr_d;
            rdy_prev_q     <= i_fir_rdy;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            underrun_q     <= underrun_d;
            overrun_q      <= overrun_d;
            timeout_q      <= timeout_d;
            busy_q         <= busy_d;
            wait_q         <= wait_d;
        end
    end

    assign o_sample_ready = ready_q;
    assign o_fir_data     = fir_data_q;
    assign o_fir_wr       = fir_wr_q;
    assign o_result       = result_q;
    assign o_result_valid = result_valid_q;
    assign o_underrun_cnt = underrun_q;
    assign o_overrun_cnt  = overrun_q;
    assign o_timeout      = timeout_q;
    assign o_busy         = busy_q;

endmodule
